// File: rtl/lcd_bus_writer_if.sv
// ----------------------------------------------------------------------------
// lcd_bus_writer_if
// Bundle of the signals that pass between the LCD text sequencer, the bus
// writer and the LCD1602 pins.
//   iRS, iStart, iDATA : write request from the sequencer (Start/Done handshake)
//   oDone              : one-cycle completion pulse back to the sequencer
//   LCD_DATA, LCD_RS,
//   LCD_RW, LCD_EN     : HD44780-style parallel bus pins
// Modports:
//   master : sequencer / bench side (drives the request, observes the rest)
//   slave  : bus writer side (consumes the request, drives Done and the pins)
// ----------------------------------------------------------------------------
interface lcd_bus_writer_if;
   logic       iRS;
   logic       iStart;
   logic [7:0] iDATA;
   logic       oDone;
   logic [7:0] LCD_DATA;
   logic       LCD_RS;
   logic       LCD_RW;
   logic       LCD_EN;

   modport master (
      output iRS, iStart, iDATA,
      input  oDone, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
   );

   modport slave (
      input  iRS, iStart, iDATA,
      output oDone, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
   );
endinterface

// File: rtl/lcd_bus_writer.sv
// ----------------------------------------------------------------------------
// lcd_bus_writer
// Turns one {RS, data byte} write request into a timed HD44780 write cycle:
// RS/DATA set up for SETUP_CYC cycles, EN high for EN_CYC cycles, RS/DATA
// held for HOLD_CYC cycles, then a one-cycle Done pulse. Write-only; the
// busy flag is never polled.
// Ports:
//   iCLK   : system clock, rising edge
//   iRST_N : asynchronous active-low reset
//   bus    : lcd_bus_writer_if.slave
//              iRS/iStart/iDATA in, oDone and LCD_DATA/LCD_RS/LCD_RW/LCD_EN out
// Parameters (legal range 1..255 each):
//   SETUP_CYC, EN_CYC, HOLD_CYC
// ----------------------------------------------------------------------------
module lcd_bus_writer #(
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned EN_CYC    = 16,
   parameter int unsigned HOLD_CYC  = 2
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   lcd_bus_writer_if.slave   bus
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_PULSE = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Each phase ends on the cycle its counter reaches N-1, so the phase
   // lasts exactly N cycles counting from the reload to zero.
   localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
   localparam logic [7:0] EN_LAST    = 8'(EN_CYC - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);

   logic [2:0] state;
   logic [7:0] counter;
   logic [7:0] counter_inc;
   logic       start_d;
   logic       accept;

   logic [7:0] lcd_data_r;
   logic       lcd_rs_r;
   logic       lcd_en_r;
   logic       done_r;

   // Only a fresh rising edge seen while idle starts a cycle; a level held
   // across Done, or an edge arriving while busy, is dropped.
   assign accept = (state == ST_IDLE) && bus.iStart && !start_d;

   // Saturating increment: the counter never wraps.
   assign counter_inc = (counter == 8'hFF) ? counter : counter + 8'd1;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state      <= ST_IDLE;
         counter    <= 8'd0;
         start_d    <= 1'b0;
         lcd_data_r <= 8'h00;
         lcd_rs_r   <= 1'b0;
         lcd_en_r   <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         start_d <= bus.iStart;
         case (state)
            ST_IDLE: begin
               lcd_en_r <= 1'b0;
               done_r   <= 1'b0;
               if (accept) begin
                  lcd_data_r <= bus.iDATA;
                  lcd_rs_r   <= bus.iRS;
                  counter    <= 8'd0;
                  state      <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (counter == SETUP_LAST) begin
                  lcd_en_r <= 1'b1;
                  counter  <= 8'd0;
                  state    <= ST_PULSE;
               end else begin
                  counter <= counter_inc;
               end
            end
            ST_PULSE: begin
               if (counter == EN_LAST) begin
                  lcd_en_r <= 1'b0;
                  counter  <= 8'd0;
                  state    <= ST_HOLD;
               end else begin
                  counter <= counter_inc;
               end
            end
            ST_HOLD: begin
               if (counter == HOLD_LAST) begin
                  done_r  <= 1'b1;
                  counter <= 8'd0;
                  state   <= ST_DONE;
               end else begin
                  counter <= counter_inc;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               counter <= 8'd0;
               state   <= ST_IDLE;
            end
            default: begin
               lcd_en_r <= 1'b0;
               done_r   <= 1'b0;
               counter  <= 8'd0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.LCD_DATA = lcd_data_r;
   assign bus.LCD_RS   = lcd_rs_r;
   assign bus.LCD_EN   = lcd_en_r;
   assign bus.LCD_RW   = 1'b0;
   assign bus.oDone    = done_r;

endmodule
